// File: rtl/svi_latch_arbiter.sv
// Round-robin owner of the shared SVI member y: one clocked writer replaces
// several latch-style drivers, with a bounded hold time per ownership.
//
// state   | meaning
// S_IDLE  | no owner; picks the next requester from rr, y holds
// S_GRANT | owner_q holds the grant; y follows i_x[owner] while it requests
module svi_latch_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(MAX_HOLD + 1)
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_x,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_gnt_id,
  output logic             o_busy,
  output logic             o_y
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               y_q, y_d;
  logic [IW-1:0]      sel;
  logic [IW:0]        sel_sum;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               owner_req;
  logic               owner_x;

  // Rotate the request vector so bit 0 is requester rr; the lowest set bit
  // of the rotated vector is the round-robin winner.
  always_comb begin
    req_dbl = {i_req, i_req} >> rr_q;
    req_rot = req_dbl[N_REQ-1:0];
    sel_sum = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sel_sum = {1'b0, rr_q} + (IW+1)'(i);
      end
    end
    if (sel_sum >= (IW+1)'(N_REQ)) begin
      sel_sum = sel_sum - (IW+1)'(N_REQ);
    end
    sel = sel_sum[IW-1:0];
  end

  assign owner_req = i_req[owner_q];
  assign owner_x   = i_x[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          state_d = S_GRANT;
          owner_d = sel;
          cnt_d   = CW'(1);
        end
      end
      S_GRANT: begin
        if (owner_req) begin
          y_d = owner_x;
        end
        if (!owner_req || (cnt_q == CW'(MAX_HOLD))) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rr_d    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  // Grant outputs decode straight from registers so reset clears them at once.
  assign o_busy   = (state_q == S_GRANT);
  assign o_gnt    = o_busy ? (N_REQ'(1) << owner_q) : '0;
  assign o_gnt_id = owner_q;
  assign o_y      = y_q;

endmodule

// File: tb/tb_svi_latch_arbiter.sv
// Bench for svi_latch_arbiter: a per-cycle reference model plus directed
// scenarios with hand-computed expectations, for MAX_HOLD=8 and MAX_HOLD=1.
module tb_svi_latch_arbiter;

  typedef struct {
    bit busy;
    int owner;
    int rr;
    int held;
    bit y;
  } mdl_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, x8, gnt8, req1, x1, gnt1;
  logic [1:0] id8, id1;
  logic       busy8, y8, busy1, y1;

  int n_cmp = 0;
  int n_err = 0;
  mdl_t m8, m1;
  int starts[$];
  int lens[$];
  int run_len = 0;
  bit prev_busy = 0;

  svi_latch_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut8 (
    .i_clk(clk), .i_arst(rst_n), .i_req(req8), .i_x(x8),
    .o_gnt(gnt8), .o_gnt_id(id8), .o_busy(busy8), .o_y(y8)
  );

  svi_latch_arbiter #(.N_REQ(4), .MAX_HOLD(1)) dut1 (
    .i_clk(clk), .i_arst(rst_n), .i_req(req1), .i_x(x1),
    .o_gnt(gnt1), .o_gnt_id(id1), .o_busy(busy1), .o_y(y1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the arbiter's rules: search from rr upward for a requester,
  // own it for at most mh cycles, copy its data into y while it requests.
  function automatic mdl_t mstep(mdl_t s, logic [3:0] req, logic [3:0] x, int mh);
    mdl_t n = s;
    int k;
    if (!s.busy) begin
      if (req != 4'b0000) begin
        k = s.rr;
        while (req[k] !== 1'b1) k = (k + 1) % 4;
        n.owner = k;
        n.busy  = 1'b1;
        n.held  = 1;
      end
    end else begin
      if (req[s.owner] === 1'b1) n.y = x[s.owner];
      if (req[s.owner] !== 1'b1 || s.held == mh) begin
        n.busy = 1'b0;
        n.rr   = (s.owner + 1) % 4;
        n.held = 0;
      end else begin
        n.held = s.held + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      m8 = mstep(m8, req8, x8, 8);
      m1 = mstep(m1, req1, x1, 1);
    end
  end

  always @(negedge clk) begin
    chk("gnt8", gnt8, m8.busy ? (32'd1 << m8.owner) : 32'd0);
    chk("busy8", busy8, m8.busy);
    chk("y8", y8, m8.y);
    if (m8.busy) chk("id8", id8, m8.owner);
    chk("gnt1", gnt1, m1.busy ? (32'd1 << m1.owner) : 32'd0);
    chk("busy1", busy1, m1.busy);
    chk("y1", y1, m1.y);
    if (m1.busy) chk("id1", id1, m1.owner);
    if (busy8 && !prev_busy) begin
      starts.push_back(int'(id8));
      run_len = 1;
    end else if (busy8) begin
      run_len++;
    end else if (prev_busy) begin
      lens.push_back(run_len);
    end
    prev_busy = busy8;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req8 = 4'b0000; x8 = 4'b0000;
    req1 = 4'b0000; x1 = 4'b0000;
    step(2);
    chk("rst_gnt", gnt8, 4'b0000);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_y", y8, 1'b0);
    rst_n = 1'b1;

    // single requester, full MAX_HOLD ownership, bubble, re-grant
    req8 = 4'b0100; x8 = 4'b0100;
    step(1); chk("t1_gnt", gnt8, 4'b0100); chk("t1_y0", y8, 1'b0);
    step(1); chk("t1_y1", y8, 1'b1);
    step(6); chk("t1_c8", gnt8, 4'b0100);
    step(1); chk("t1_bubble", gnt8, 4'b0000);
    step(1); chk("t1_regrant", gnt8, 4'b0100);
    req8 = 4'b0000; x8 = 4'b0000;
    step(1); chk("t1_rel", gnt8, 4'b0000); chk("t1_nowrite", y8, 1'b1);

    // wrap-around from rr=3
    req8 = 4'b0011;
    step(1); chk("t4_id", id8, 2'd0); chk("t4_busy", busy8, 1'b1);
    req8 = 4'b0000;
    step(2);

    // round robin with everyone requesting
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    starts.delete();
    lens.delete();
    req8 = 4'b1111; x8 = 4'b1010;
    step(40);
    for (int k = 0; k < 5; k++)
      chk("t2_order", (k < starts.size()) ? starts[k] : 99, exp_order[k]);
    for (int k = 0; k < 4; k++)
      chk("t2_len", (k < lens.size()) ? lens[k] : 99, 8);

    // early release by owner 1 in its third grant cycle
    req8 = 4'b0000;
    step(1);
    req8 = 4'b0010; x8 = 4'b0010;
    step(1); chk("t3_gnt", gnt8, 4'b0010);
    step(1); chk("t3_y1", y8, 1'b1);
    x8 = 4'b0000;
    step(1); chk("t3_y0", y8, 1'b0);
    req8 = 4'b0000; x8 = 4'b0010;
    step(1); chk("t3_rel", gnt8, 4'b0000); chk("t3_nowrite", y8, 1'b0);
    req8 = 4'b1111; x8 = 4'b1111;
    step(1); chk("t3_rr2", id8, 2'd2);

    // asynchronous reset during grant cycle 4
    step(3); chk("t5_y_pre", y8, 1'b1); chk("t5_busy_pre", busy8, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_gnt", gnt8, 4'b0000);
    chk("t5_busy", busy8, 1'b0);
    chk("t5_y", y8, 1'b0);
    req8 = 4'b1000; x8 = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(1); chk("t5_id", id8, 2'd3); chk("t5_gnt3", gnt8, 4'b1000);
    req8 = 4'b0000;
    step(2);

    // MAX_HOLD=1: grant and idle alternate, one write per grant
    req1 = 4'b0001; x1 = 4'b0001;
    step(1); chk("t6_g1", gnt1, 4'b0001); chk("t6_y0", y1, 1'b0);
    step(1); chk("t6_i1", gnt1, 4'b0000); chk("t6_y1", y1, 1'b1);
    x1 = 4'b0000;
    step(1); chk("t6_g2", gnt1, 4'b0001); chk("t6_yhold", y1, 1'b1);
    step(1); chk("t6_i2", gnt1, 4'b0000); chk("t6_y2", y1, 1'b0);
    req1 = 4'b0000;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/svi_latch_arbiter.md
Name: svi_latch_arbiter

Overview:
- Shares write access to the single-bit shared member y of an SVI instance between N_REQ requesters, so that only one driver updates y at a time.
- Round-robin arbitration with a bounded hold time. The winning requester's data is registered into y while it holds the grant.
- Sits between the requesting modules and the SVI instance. It replaces multiple independent latch-style drivers of y with one clocked owner.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; legal range 1..255.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst  input  1  asynchronous reset, active-low.
- i_req  input  N_REQ  request vector; bit k high means requester k wants to write y.
- i_x  input  N_REQ  write data; bit k is requester k's value for y.
- o_gnt  output  N_REQ  one-hot grant vector; all-zero when no owner.
- o_gnt_id  output  $clog2(N_REQ)  index of the current owner; valid only while o_busy=1.
- o_busy  output  1  high while any grant is active.
- o_y  output  1  registered value of shared member y, connected to the SVI instance.

Behaviour:
- Reset (i_arst=0, asynchronous, any time):
  - o_gnt=0, o_gnt_id=0, o_busy=0, o_y=0.
  - Round-robin pointer rr=0, hold counter cnt=0, state=IDLE.
  - Reset asserted mid-grant drops the grant immediately. No write of y occurs at the edge where reset is active.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If i_req==0, stay in IDLE; o_y holds.
  - Otherwise select the first set bit of i_req scanning upward from index rr, wrapping at N_REQ.
  - On the next edge: state=GRANT, owner=selected index, o_gnt=1<<owner, o_gnt_id=owner, o_busy=1, cnt=1.
  - Latency from request to grant is exactly 1 cycle. o_y is not written in IDLE.
- GRANT, each edge:
  - If i_req[owner]=1, then o_y <= i_x[owner].
  - If i_req[owner]=0 or cnt==MAX_HOLD:
    - next state=IDLE; o_gnt=0, o_busy=0.
    - rr=(owner+1) mod N_REQ.
    - cnt=0.
  - Otherwise cnt=cnt+1 and the grant is held.
  - Requests from other requesters are ignored while in GRANT.
- Bubble: every release is followed by one IDLE cycle, with o_gnt=0, before the next grant. There is no back-to-back handover.
- Maximum ownership:
  - An owner holding i_req high receives exactly MAX_HOLD grant cycles and exactly MAX_HOLD writes.
  - It may win again only after every other active requester has been served once.
- Dropped request: if the owner drops i_req during grant cycle k, there is no write on that edge and the grant ends after cycle k.
- Fairness: with all requesters continuously requesting, grant order is 0,1,...,N_REQ-1,0,... with wrap-around at N_REQ-1 to 0.
- Simultaneous events: a requester that deasserts in the same cycle it would have been chosen in IDLE is not granted, because selection uses the current-cycle i_req.
- Invariants: o_gnt is always one-hot or zero. o_busy equals |o_gnt. o_y changes only on an edge in GRANT.
- cnt width is $clog2(MAX_HOLD+1); cnt never exceeds MAX_HOLD.

Test Plan:
1. Reset then single request, with N_REQ=4, MAX_HOLD=8:
   - Stimulus: i_req=4'b0100 held, i_x[2]=1.
   - Response: o_gnt=4'b0100 one cycle later; o_y=1 after the first grant edge; the grant lasts 8 cycles, then 1 cycle of o_gnt=0, then re-grant to 2.
2. Round robin:
   - Stimulus: i_req=4'b1111 held for 40 cycles.
   - Response: grant order 0,1,2,3,0; each grant 8 cycles; 1 idle cycle between grants.
3. Early release:
   - Stimulus: owner 1 drops i_req in its 3rd grant cycle, while i_x[1] toggles 1,0,1.
   - Response: o_y sequence 1,0, with no third write; o_gnt=0 the next cycle; rr=2.
4. Wrap-around:
   - Stimulus: rr=3 (after owner 2 releases), i_req=4'b0011.
   - Response: requester 0 is granted, not 1.
5. Reset mid-grant:
   - Stimulus: pull i_arst low asynchronously during grant cycle 4.
   - Response: o_gnt=0, o_y=0 and o_busy=0 immediately, before the next edge; after release with i_req=4'b1000, the grant goes to 3 (rr restarted at 0).
6. MAX_HOLD=1:
   - Stimulus: i_req=4'b0001 held.
   - Response: grant and idle alternate every cycle; one write per grant.
